post_uart: RTL and testbench



---
 rtl/post_uart.sv | 230 +++++++++++++++++++++++
 tb/tb_post_uart.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/post_uart.sv
// post_uart: captures POST-code writes to an I/O port into a small FIFO and
// sends them out as 8N1 UART on an otherwise unused pin.
//
// Ports:
//   iClk     bus clock
//   iRst     synchronous, active-high reset
//   iAddr    CPU address; only [15:0] is decoded
//   iWrData  CPU write data
//   iWr      I/O write strobe (one cycle per write)
//   iRd      I/O read strobe
//   oRdData  read data: last code at PORT, status at PORT+1
//   oSel     read select for the CPU data mux
//   oTx      UART TX line, idle high
//   oBusy    FIFO non-empty or frame in flight (registered)
//
// Status byte at PORT+1: {count[4:0], tx_busy, empty, overflow}.
//
// Optional feature macro POST_UART_HEX_EN: when defined, each byte goes out as
// two uppercase ASCII hex digits followed by CR LF; otherwise it is sent raw.

module post_uart #(
  parameter int unsigned CLK_IN = 20000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16,
  parameter logic [15:0] PORT   = 16'h0080
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [19:0] iAddr,
  input  logic [7:0]  iWrData,
  input  logic        iWr,
  input  logic        iRd,
  output logic [7:0]  oRdData,
  output logic        oSel,
  output logic        oTx,
  output logic        oBusy
);

  localparam int unsigned DIV  = CLK_IN / BAUD;
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DepthC = 5'(DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [2:0]        r_bit, w_bit_d;
  logic [7:0]        r_shift, w_shift_d;
  logic [7:0]        r_byte, w_byte_d;
  logic [7:0]        r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [4:0]        r_count;
  logic              r_ovf, r_tx, r_busy;
  logic [7:0]        r_last;

  logic w_hit_c, w_hit_s, w_wr_code, w_push, w_pop, w_ovf_evt;
  logic w_empty, w_full, w_tx_busy, w_tx, w_more_chars, w_more;
  logic w_cnt_last, w_cnt_early;
  logic [7:0] w_char, w_status, w_rd_data;
  logic w_unused_addr;

`ifdef POST_UART_HEX_EN
  logic [1:0] r_idx, w_idx_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    unique case (r_idx)
      2'd0:    w_char = hex_char(r_byte[7:4]);
      2'd1:    w_char = hex_char(r_byte[3:0]);
      2'd2:    w_char = 8'h0D;
      default: w_char = 8'h0A;
    endcase
  end
  assign w_more_chars = (r_idx != 2'd3);
`else
  assign w_char       = r_byte;
  assign w_more_chars = 1'b0;
`endif

  assign w_unused_addr = ^iAddr[19:16];

  assign w_hit_c   = (iAddr[15:0] == PORT);
  assign w_hit_s   = (iAddr[15:0] == PORT + 16'd1);
  assign w_empty   = (r_count == 5'd0);
  assign w_full    = (r_count == DepthC);
  assign w_tx_busy = (r_state != StIdle);
  assign w_wr_code = iWr & w_hit_c;
  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign w_push    = w_wr_code & (~w_full | w_pop);
  assign w_ovf_evt = w_wr_code & w_full & ~w_pop;

  assign w_status  = {r_count, w_tx_busy, w_empty, r_ovf};
  assign oSel      = iRd & (w_hit_c | w_hit_s);

  always_comb begin
    w_rd_data = 8'h00;
    if (w_hit_c)      w_rd_data = r_last;
    else if (w_hit_s) w_rd_data = w_status;
  end
  assign oRdData = w_rd_data;

  assign w_cnt_last  = (r_cnt == CntW'(DIV - 1));
  // The LOAD cycle doubles as the final stop-bit clock when frames run back to back.
  assign w_cnt_early = (r_cnt == CntW'(DIV - 2));
  assign w_more      = w_more_chars | ~w_empty;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_byte_d  = r_byte;
    w_pop     = 1'b0;
    w_tx      = 1'b1;
`ifdef POST_UART_HEX_EN
    w_idx_d   = r_idx;
`endif
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_byte_d  = r_mem[r_rptr];
`ifdef POST_UART_HEX_EN
          w_idx_d   = 2'd0;
`endif
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        w_shift_d = w_char;
        w_cnt_d   = '0;
        w_state_d = StStart;
      end
      StStart: begin
        w_tx = 1'b0;
        if (w_cnt_last) begin
          w_cnt_d   = '0;
          w_bit_d   = 3'd0;
          w_state_d = StData;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StData: begin
        w_tx = r_shift[0];
        if (w_cnt_last) begin
          w_cnt_d   = '0;
          w_shift_d = {1'b0, r_shift[7:1]};
          w_bit_d   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_d = StStop;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StStop: begin
        if ((w_cnt_early && w_more) || w_cnt_last) begin
          if (w_more_chars) begin
`ifdef POST_UART_HEX_EN
            w_idx_d   = r_idx + 2'd1;
`endif
            w_state_d = StLoad;
          end else if (!w_empty) begin
            w_pop     = 1'b1;
            w_byte_d  = r_mem[r_rptr];
`ifdef POST_UART_HEX_EN
            w_idx_d   = 2'd0;
`endif
            w_state_d = StLoad;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (w_push) r_mem[r_wptr] <= iWrData;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_byte  <= 8'h00;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 5'd0;
      r_ovf   <= 1'b0;
      r_last  <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
`ifdef POST_UART_HEX_EN
      r_idx   <= 2'd0;
`endif
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_byte  <= w_byte_d;
`ifdef POST_UART_HEX_EN
      r_idx   <= w_idx_d;
`endif
      r_tx    <= w_tx;
      r_busy  <= w_tx_busy | ~w_empty;
      if (w_wr_code) r_last <= iWrData;
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + 5'd1;
      else if (w_pop && !w_push) r_count <= r_count - 5'd1;
      // An overflow in the same cycle as a status read wins.
      if (w_ovf_evt)               r_ovf <= 1'b1;
      else if (iRd && w_hit_s)     r_ovf <= 1'b0;
    end
  end

  assign oTx   = r_tx;
  assign oBusy = r_busy;

endmodule

// File: tb/tb_post_uart.sv
// Bench for post_uart: DIV = 10 clocks per bit. Expected UART characters and
// read data are queued by the stimulus; a serial receiver and a read monitor
// pop and compare independently.

module tb_post_uart;

  localparam int unsigned Div       = 10;
  localparam int unsigned FrameClks = 10 * Div;
`ifdef POST_UART_HEX_EN
  localparam int unsigned Cpb = 4;
`else
  localparam int unsigned Cpb = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [7:0]  rdata;
  logic        sel, tx, busy;

  post_uart #(
    .CLK_IN(1000000),
    .BAUD  (100000),
    .DEPTH (16),
    .PORT  (16'h0080)
  ) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iAddr  (addr),
    .iWrData(wdata),
    .iWr    (wr),
    .iRd    (rd),
    .oRdData(rdata),
    .oSel   (sel),
    .oTx    (tx),
    .oBusy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  int starts[$];
  int frames_done = 0;
  bit rx_abort = 1'b0;
  int fall_cyc = -1;
  bit prev_busy = 1'b0;
  logic [7:0] rd_exp;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    string hx;
    hx = "0123456789ABCDEF";
    return hx[int'(n)];
  endfunction

  task automatic push_exp(input logic [7:0] b);
`ifdef POST_UART_HEX_EN
    exp_q.push_back(asc(b[7:4]));
    exp_q.push_back(asc(b[3:0]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(b);
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [19:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; addr = '0;
  endtask

  task automatic bus_rd(input logic [19:0] a, input logic [7:0] e, input bit hit);
    addr = a; rd = 1'b1;
    if (hit) rd_q.push_back(e);
    @(posedge clk); #1;
    rd = 1'b0; addr = '0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("frames_timeout", frames_done, target);
  endtask

  task automatic check_contig();
    for (int k = 1; k < starts.size(); k++)
      check("frame_spacing", starts[k] - starts[k-1], FrameClks);
  endtask

  task automatic check_fall();
    tick(3);
    if (starts.size() == 0) check("busy_fall_noframe", 0, 1);
    else check("busy_fall", fall_cyc, starts[starts.size()-1] + FrameClks);
  endtask

  // Serial receiver: one sample per clock, each bit must hold for Div clocks.
  initial begin : uart_mon
    logic [9:0] v;
    bit ok;
    logic [7:0] got, want;
    int st;
    forever begin
      @(negedge clk);
      if (tx !== 1'b0 || rx_abort) continue;
      st = cyc;
      starts.push_back(st);
      ok = 1'b1;
      v  = '0;
      for (int c = 1; c < FrameClks; c++) begin
        @(negedge clk);
        if (rx_abort) break;
        if (c % Div == 0) v[c / Div] = tx;
        else if (tx !== v[c / Div]) ok = 1'b0;
      end
      if (rx_abort) continue;
      if (v[9] !== 1'b1) ok = 1'b0;
      got = v[8:1];
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL frame: got unexpected %02h at cycle %0d, expected none", got, st);
      end else begin
        want = exp_q.pop_front();
        if (!ok || got !== want) begin
          n_bad++;
          $display("FAIL frame: got %02h (well-formed=%0d) at cycle %0d, expected %02h",
                   got, ok, st, want);
        end
      end
      frames_done++;
    end
  end

  // Read monitor: every asserted select must match the next queued read.
  always @(negedge clk) begin
    if (sel === 1'b1) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_sel: got select with data %02h at addr %05h, expected no select",
                 rdata, addr);
      end else begin
        rd_exp = rd_q.pop_front();
        if (rdata !== rd_exp) begin
          n_bad++;
          $display("FAIL rd_data: got %02h at addr %05h, expected %02h", rdata, addr, rd_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (prev_busy && busy === 1'b0) fall_cyc = cyc;
    prev_busy = (busy === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bit steady;
    int n;

    // Reset and idle line
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_rdata", int'(rdata), 0);
    tick(1);
    steady = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) steady = 1'b0;
    end
    check("idle_tx", int'(steady), 1);
    tick(1);
    bus_rd(20'h00081, 8'h02, 1'b1);
    bus_rd(20'h00082, 8'h00, 1'b0);
    tick(2);

    // Single code 0x5A
    starts.delete();
    base = frames_done;
    push_exp(8'h5A);
    bus_wr(20'h00080, 8'h5A);
    bus_rd(20'h00080, 8'h5A, 1'b1);
    bus_rd(20'h00081, 8'h06, 1'b1);
    wait_frames(base + Cpb, Cpb * FrameClks + 100);
    check_contig();
    check_fall();

    // Overflow: 18 writes on consecutive cycles, the last one dropped
    starts.delete();
    base = frames_done;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) push_exp(8'(i));
      bus_wr(20'h00080, 8'(i));
    end
    bus_rd(20'h00081, 8'h85, 1'b1);
    bus_rd(20'h00081, 8'h84, 1'b1);
    bus_rd(20'h00080, 8'h11, 1'b1);
    wait_frames(base + 17 * Cpb, 17 * Cpb * FrameClks + 200);
    check_contig();
    check_fall();

    // Reset during DATA of the second frame with three entries queued
    starts.delete();
    base = frames_done;
    push_exp(8'hA1);
    push_exp(8'hB2);
    push_exp(8'hC3);
    bus_wr(20'h00080, 8'hA1);
    bus_wr(20'h00080, 8'hB2);
    bus_wr(20'h00080, 8'hC3);
    n = 0;
    while (starts.size() < 2 && n < 3 * FrameClks) begin
      tick(1);
      n++;
    end
    check("second_start", (starts.size() >= 2) ? 1 : 0, 1);
    tick(30);
    rx_abort = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", int'(tx), 1);
    exp_q.delete();
    tick(2);
    rx_abort = 1'b0;
    bus_rd(20'h00081, 8'h02, 1'b1);
    bus_rd(20'h00080, 8'h00, 1'b1);
    steady = 1'b1;
    repeat (6 * FrameClks) begin
      @(negedge clk);
      if (tx !== 1'b1) steady = 1'b0;
    end
    check("post_rst_quiet", int'(steady), 1);
    check("post_rst_frames", frames_done, base + 1);
    check("post_rst_busy", int'(busy), 0);
    tick(1);

    // Aliases are ignored; upper address bits are not decoded
    bus_wr(20'h00081, 8'h77);
    bus_wr(20'h00180, 8'h77);
    tick(3);
    bus_rd(20'h00080, 8'h00, 1'b1);
    bus_rd(20'h00081, 8'h02, 1'b1);
    @(negedge clk);
    check("alias_busy", int'(busy), 0);
    tick(1);
    starts.delete();
    base = frames_done;
    push_exp(8'h3C);
    bus_wr(20'h10080, 8'h3C);
    bus_rd(20'h00080, 8'h3C, 1'b1);
    wait_frames(base + Cpb, Cpb * FrameClks + 100);
    check_contig();
    check_fall();

    tick(5);
    check("exp_q_left", exp_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
